// File: rtl/fp_unpack_align.sv
// rtl/fp_unpack_align.sv - unpack two IEEE-754 singles and align the smaller-exponent mantissa
module fp_unpack_align #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int GRS_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [EXP_W+FRAC_W:0]       a_in,
    input  logic [EXP_W+FRAC_W:0]       b_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EXP_W-1:0]            exp_out,
    output logic [FRAC_W+GRS_W:0]       mantis_big,
    output logic [FRAC_W+GRS_W:0]       mantis_small,
    output logic                        sign_big,
    output logic                        sign_small,
    output logic                        swapped,
    output logic                        special
);

    localparam int WORD_W = 1 + EXP_W + FRAC_W;
    localparam int MANT_W = FRAC_W + 1 + GRS_W;
    localparam int CNT_W  = $clog2(MANT_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [EXP_W-1:0]    exp_out_q, exp_out_d;
    logic [MANT_W-1:0]   mantis_big_q, mantis_big_d;
    logic [MANT_W-1:0]   mantis_small_q, mantis_small_d;
    logic                sign_big_q, sign_big_d;
    logic                sign_small_q, sign_small_d;
    logic                swapped_q, swapped_d;
    logic                special_q, special_d;

    logic                a_sign, b_sign;
    logic [EXP_W-1:0]    a_exp, b_exp;
    logic [FRAC_W-1:0]   a_frac, b_frac;
    logic                a_hidden, b_hidden;
    logic [EXP_W-1:0]    a_eff, b_eff;
    logic [MANT_W-1:0]   a_mant, b_mant;
    logic                b_is_big;
    logic                in_special;
    logic [EXP_W-1:0]    eff_big, eff_small, exp_diff;
    logic [CNT_W-1:0]    count_init;

    // Field extraction and alignment distance for the operands on the input bus
    always_comb begin
        a_sign   = a_in[WORD_W-1];
        b_sign   = b_in[WORD_W-1];
        a_exp    = a_in[WORD_W-2 -: EXP_W];
        b_exp    = b_in[WORD_W-2 -: EXP_W];
        a_frac   = a_in[FRAC_W-1:0];
        b_frac   = b_in[FRAC_W-1:0];
        // zero/denormal operands have no hidden bit and sit at exponent 1
        a_hidden = |a_exp;
        b_hidden = |b_exp;
        a_eff    = a_hidden ? a_exp : EXP_W'(1);
        b_eff    = b_hidden ? b_exp : EXP_W'(1);
        a_mant   = {a_hidden, a_frac, {GRS_W{1'b0}}};
        b_mant   = {b_hidden, b_frac, {GRS_W{1'b0}}};
        // equal exponents keep A as the big operand
        b_is_big   = b_eff > a_eff;
        in_special = (&a_exp) | (&b_exp);
        eff_big    = b_is_big ? b_eff : a_eff;
        eff_small  = b_is_big ? a_eff : b_eff;
        exp_diff   = eff_big - eff_small;
        // beyond MANT_W shifts everything is already in the sticky bit
        if (in_special) begin
            count_init = '0;
        end else if (exp_diff > EXP_W'(MANT_W)) begin
            count_init = CNT_W'(MANT_W);
        end else begin
            count_init = CNT_W'(exp_diff);
        end
    end

    // Next-state and datapath updates for accept, align-shift and handshake
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        exp_out_d      = exp_out_q;
        mantis_big_d   = mantis_big_q;
        mantis_small_d = mantis_small_q;
        sign_big_d     = sign_big_q;
        sign_small_d   = sign_small_q;
        swapped_d      = swapped_q;
        special_d      = special_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // special operands load a zero count, so they pass through
                    // ALIGN without shifting and keep the same one-edge latency
                    state_d        = ST_ALIGN;
                    count_d        = count_init;
                    exp_out_d      = eff_big;
                    mantis_big_d   = b_is_big ? b_mant : a_mant;
                    mantis_small_d = b_is_big ? a_mant : b_mant;
                    sign_big_d     = b_is_big ? b_sign : a_sign;
                    sign_small_d   = b_is_big ? a_sign : b_sign;
                    swapped_d      = b_is_big;
                    special_d      = in_special;
                end
            end
            ST_ALIGN: begin
                if (count_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    // bit 0 accumulates everything shifted past it
                    mantis_small_d = {1'b0, mantis_small_q[MANT_W-1:2],
                                      mantis_small_q[1] | mantis_small_q[0]};
                    count_d        = count_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            exp_out_q      <= '0;
            mantis_big_q   <= '0;
            mantis_small_q <= '0;
            sign_big_q     <= 1'b0;
            sign_small_q   <= 1'b0;
            swapped_q      <= 1'b0;
            special_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            exp_out_q      <= exp_out_d;
            mantis_big_q   <= mantis_big_d;
            mantis_small_q <= mantis_small_d;
            sign_big_q     <= sign_big_d;
            sign_small_q   <= sign_small_d;
            swapped_q      <= swapped_d;
            special_q      <= special_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign exp_out      = exp_out_q;
    assign mantis_big   = mantis_big_q;
    assign mantis_small = mantis_small_q;
    assign sign_big     = sign_big_q;
    assign sign_small   = sign_small_q;
    assign swapped      = swapped_q;
    assign special      = special_q;

endmodule

// File: tb/tb_fp_unpack_align.sv
// tb/tb_fp_unpack_align.sv - directed-vector bench for fp_unpack_align
module tb_fp_unpack_align;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [27:0] mantis_big;
    logic [27:0] mantis_small;
    logic        sign_big;
    logic        sign_small;
    logic        swapped;
    logic        special;

    int tests_run;
    int tests_failed;

    fp_unpack_align dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .exp_out      (exp_out),
        .mantis_big   (mantis_big),
        .mantis_small (mantis_small),
        .sign_big     (sign_big),
        .sign_small   (sign_small),
        .swapped      (swapped),
        .special      (special)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // drive one operand pair, accept it, and count edges until out_valid
    task automatic launch(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        check("in_ready_pre", {31'b0, in_ready}, 32'd1);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic expect_result(input string tag, input int lat, input int lat_exp,
                                 input logic [7:0] e, input logic [27:0] mb,
                                 input logic [27:0] ms, input logic sb, input logic ss,
                                 input logic sw, input logic sp);
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        check({tag, "_exp_out"}, {24'b0, exp_out}, {24'b0, e});
        check({tag, "_mantis_big"}, {4'b0, mantis_big}, {4'b0, mb});
        check({tag, "_mantis_small"}, {4'b0, mantis_small}, {4'b0, ms});
        check({tag, "_signs"}, {30'b0, sign_big, sign_small}, {30'b0, sb, ss});
        check({tag, "_swapped"}, {31'b0, swapped}, {31'b0, sw});
        check({tag, "_special"}, {31'b0, special}, {31'b0, sp});
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_rel_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_rel_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    int lat;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_exp_out", {24'b0, exp_out}, 32'd0);
        check("rst_mantis", {4'b0, mantis_big | mantis_small}, 32'd0);
        check("rst_flags", {28'b0, sign_big, sign_small, swapped, special}, 32'd0);
        rst_n = 1'b1;

        // 1.0 + 1.0: equal exponents, A stays big
        launch(32'h3F800000, 32'h3F800000, lat);
        expect_result("eq", lat, 1, 8'd127, 28'h8000000, 28'h8000000, 1'b0, 1'b0, 1'b0, 1'b0);
        release_result("eq");

        // 0.5 + 1.0: B is big, one shift
        launch(32'h3F000000, 32'h3F800000, lat);
        expect_result("swap", lat, 2, 8'd127, 28'h8000000, 28'h4000000, 1'b0, 1'b0, 1'b1, 1'b0);
        release_result("swap");

        // -2.0 + 1.0: sign follows the big operand
        launch(32'hC0000000, 32'h3F800000, lat);
        expect_result("neg", lat, 2, 8'd128, 28'h8000000, 28'h4000000, 1'b1, 1'b0, 1'b0, 1'b0);
        release_result("neg");

        // diff 30 capped at 28: only sticky survives
        launch(32'h3F800000, 32'h30800000, lat);
        expect_result("cap", lat, 29, 8'd127, 28'h8000000, 28'h0000001, 1'b0, 1'b0, 1'b0, 1'b0);
        release_result("cap");

        // diff 4: 1.5 mantissa shifted by 4
        launch(32'h3F800000, 32'h3DC00000, lat);
        expect_result("d4", lat, 5, 8'd127, 28'h8000000, 28'h0C00000, 1'b0, 1'b0, 1'b0, 1'b0);
        release_result("d4");

        // denormal vs smallest normal: tie at effective exponent 1
        launch(32'h00000001, 32'h00800000, lat);
        expect_result("denorm", lat, 1, 8'd1, 28'h0000010, 28'h8000000, 1'b0, 1'b0, 1'b0, 1'b0);
        release_result("denorm");

        // both zero
        launch(32'h00000000, 32'h00000000, lat);
        expect_result("zero", lat, 1, 8'd1, 28'h0000000, 28'h0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        release_result("zero");

        // Inf operand: no shifting, held while out_ready stays low
        launch(32'h7F800000, 32'h3F800000, lat);
        expect_result("inf", lat, 1, 8'd255, 28'h8000000, 28'h8000000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_exp_out", {24'b0, exp_out}, 32'd255);
            check("hold_mantis_small", {4'b0, mantis_small}, 32'h8000000);
        end
        release_result("inf");

        // reset during ALIGN of the capped case
        @(negedge clk);
        a_in     = 32'h3F800000;
        b_in     = 32'h30800000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_align_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_align_in_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_exp_out", {24'b0, exp_out}, 32'd0);
        check("abort_mantis", {4'b0, mantis_big | mantis_small}, 32'd0);
        check("abort_flags", {28'b0, sign_big, sign_small, swapped, special}, 32'd0);

        launch(32'h3F800000, 32'h3F800000, lat);
        expect_result("post_rst", lat, 1, 8'd127, 28'h8000000, 28'h8000000, 1'b0, 1'b0, 1'b0, 1'b0);
        release_result("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
